yarp_data_mem: RTL and testbench

YARP_DATA_MEM -- requirements
Module: yarp_data_mem

---
 rtl/yarp_data_mem.sv | 160 ++++++++++++++++
 tb/tb_yarp_data_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/yarp_data_mem.sv
// Single-cycle data memory with byte/half/word access, a sticky fault flag
// and optional access counters (enable with `define YARP_DMEM_STATS_EN).
module yarp_data_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
`ifdef YARP_DMEM_STATS_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
`endif
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  logic [31:0]      mem_q [DEPTH];

  logic [31:0]      off_c;
  logic [IDX_W-1:0] idx_c;
  logic             fault_c;
  logic [3:0]       lane_en_c;
  logic [31:0]      lane_data_c;
  logic [31:0]      rd_shift_c;
  logic [31:0]      rd_val_c;
  logic             wr_en_c;
  logic             rd_en_c;

  logic [31:0]      rd_data_q, rd_data_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  // Address decode and fault detection; offset wraps for addresses below BASE_ADDR
  always_comb begin
    off_c   = data_mem_addr_i - BASE_ADDR;
    idx_c   = off_c[IDX_W+1:2];
    fault_c = 1'b0;
    if (data_mem_req_i) begin
      if (off_c >= MEM_BYTES)                                          fault_c = 1'b1;
      if (data_mem_byte_en_i == 2'b10)                                 fault_c = 1'b1;
      if (data_mem_byte_en_i == SZ_HALF && data_mem_addr_i[0])         fault_c = 1'b1;
      if (data_mem_byte_en_i == SZ_WORD && data_mem_addr_i[1:0] != 2'b00) fault_c = 1'b1;
    end
  end

  // Lane enables and lane-replicated write data
  always_comb begin
    lane_en_c   = 4'b0000;
    lane_data_c = data_mem_wr_data_i;
    case (data_mem_byte_en_i)
      SZ_BYTE: begin
        lane_en_c   = 4'b0001 << data_mem_addr_i[1:0];
        lane_data_c = {4{data_mem_wr_data_i[7:0]}};
      end
      SZ_HALF: begin
        lane_en_c   = 4'b0011 << {data_mem_addr_i[1], 1'b0};
        lane_data_c = {2{data_mem_wr_data_i[15:0]}};
      end
      SZ_WORD: begin
        lane_en_c   = 4'b1111;
        lane_data_c = data_mem_wr_data_i;
      end
      default: begin
        lane_en_c   = 4'b0000;
        lane_data_c = data_mem_wr_data_i;
      end
    endcase
  end

  assign wr_en_c = data_mem_req_i & data_mem_wr_i & ~fault_c & reset_n;
  assign rd_en_c = data_mem_req_i & ~data_mem_wr_i;

  // Storage has no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en_c[b]) mem_q[idx_c][b*8 +: 8] <= lane_data_c[b*8 +: 8];
      end
    end
  end

  // Read alignment: shift addressed lane to bit 0, then zero-extend by size
  always_comb begin
    rd_shift_c = mem_q[idx_c] >> {data_mem_addr_i[1:0], 3'b000};
    case (data_mem_byte_en_i)
      SZ_BYTE: rd_val_c = {24'h0, rd_shift_c[7:0]};
      SZ_HALF: rd_val_c = {16'h0, rd_shift_c[15:0]};
      default: rd_val_c = rd_shift_c;
    endcase
  end

  // Next-state for registered outputs
  always_comb begin
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (rd_en_c) rd_data_d = fault_c ? 32'h0 : rd_val_c;
    if (fault_c && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = data_mem_addr_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign data_mem_rd_data_o = rd_data_q;
  assign err_o              = err_q;
  assign err_addr_o         = err_addr_q;

`ifdef YARP_DMEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Saturating counts of accepted, non-faulting accesses
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_en_c && !fault_c && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
    if (wr_en_c && wr_cnt_q != 32'hFFFF_FFFF)             wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_yarp_data_mem.sv
// Self-checking bench for yarp_data_mem: vector table through a scoreboard queue,
// plus hand sequences for reset corners (counters checked with YARP_DMEM_STATS_EN).
module tb_yarp_data_mem;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  be;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] err_addr;
`ifdef YARP_DMEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int passed = 0;
  int total  = 0;

  yarp_data_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .data_mem_req_i     (req),
    .data_mem_addr_i    (addr),
    .data_mem_byte_en_i (be),
    .data_mem_wr_i      (wr),
    .data_mem_wr_data_i (wdata),
    .data_mem_rd_data_o (rdata),
    .err_o              (err),
    .err_addr_o         (err_addr)
`ifdef YARP_DMEM_STATS_EN
    ,
    .rd_cnt_o           (rd_cnt),
    .wr_cnt_o           (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        req;
    logic        wr;
    logic [1:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_ea;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
    logic [31:0] ea;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic add(input string n, input logic rq, input logic w, input logic [1:0] b,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                     input logic ee, input logic [31:0] ea);
    vec_t v;
    v = '{name: n, req: rq, wr: w, be: b, addr: a, wd: d, exp_rd: er, exp_err: ee, exp_ea: ea};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rq, input logic w, input logic [1:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = rq; wr = w; be = b; addr = a; wdata = d;
  endtask

  // Drive one vector, queue its expectation, pop and compare after the edge
  task automatic apply(input vec_t v);
    exp_t e, got;
    drive(v.req, v.wr, v.be, v.addr, v.wd);
    e = '{name: v.name, rd: v.exp_rd, err: v.exp_err, ea: v.exp_ea};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.name, ".rd"},  rdata,           got.rd);
    chk({got.name, ".err"}, {31'h0, err},    {31'h0, got.err});
    chk({got.name, ".ea"},  err_addr,        got.ea);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b1;
    req = 1'b0; wr = 1'b0; be = 2'b00; addr = 32'h0; wdata = 32'h0;

    //        name     req wr  be     addr          wdata          exp_rd         err   err_addr
    add("w_dead",   1, 1, 2'b11, 32'h2000, 32'hDEADBEEF, 32'h0000_0000, 0, 32'h0);
    add("r_dead",   1, 0, 2'b11, 32'h2000, 32'h0,        32'hDEADBEEF, 0, 32'h0);
    add("w_1122",   1, 1, 2'b11, 32'h2000, 32'h11223344, 32'hDEADBEEF, 0, 32'h0);
    add("wb_5a",    1, 1, 2'b00, 32'h2003, 32'hFFFFFF5A, 32'hDEADBEEF, 0, 32'h0);
    add("rw_5a",    1, 0, 2'b11, 32'h2000, 32'h0,        32'h5A223344, 0, 32'h0);
    add("rb_2003",  1, 0, 2'b00, 32'h2003, 32'h0,        32'h0000005A, 0, 32'h0);
    add("rb_2001",  1, 0, 2'b00, 32'h2001, 32'h0,        32'h00000033, 0, 32'h0);
    add("rh_2002",  1, 0, 2'b01, 32'h2002, 32'h0,        32'h00005A22, 0, 32'h0);
    add("w_2004",   1, 1, 2'b11, 32'h2004, 32'h01020304, 32'h00005A22, 0, 32'h0);
    add("wh_cafe",  1, 1, 2'b01, 32'h2006, 32'hAAAACAFE, 32'h00005A22, 0, 32'h0);
    add("rh_cafe",  1, 0, 2'b01, 32'h2006, 32'h0,        32'h0000CAFE, 0, 32'h0);
    add("rw_2004",  1, 0, 2'b11, 32'h2004, 32'h0,        32'hCAFE0304, 0, 32'h0);
    add("wh_beef",  1, 1, 2'b01, 32'h2004, 32'h5555BEEF, 32'hCAFE0304, 0, 32'h0);
    add("rw_beef",  1, 0, 2'b11, 32'h2004, 32'h0,        32'hCAFEBEEF, 0, 32'h0);
    add("noreq_w",  0, 1, 2'b11, 32'h2004, 32'h0,        32'hCAFEBEEF, 0, 32'h0);
    add("rw_keep",  1, 0, 2'b11, 32'h2004, 32'h0,        32'hCAFEBEEF, 0, 32'h0);
    add("noreq_r",  0, 0, 2'b00, 32'h2000, 32'h0,        32'hCAFEBEEF, 0, 32'h0);
    add("w_last",   1, 1, 2'b11, 32'h203C, 32'h77778888, 32'hCAFEBEEF, 0, 32'h0);
    add("r_last",   1, 0, 2'b11, 32'h203C, 32'h0,        32'h77778888, 0, 32'h0);
    add("rb_2000",  1, 0, 2'b00, 32'h2000, 32'h0,        32'h00000044, 0, 32'h0);
    add("w_mis",    1, 1, 2'b11, 32'h2002, 32'h12345678, 32'h00000044, 1, 32'h2002);
    add("r_after",  1, 0, 2'b11, 32'h2000, 32'h0,        32'h5A223344, 1, 32'h2002);
    add("r_below",  1, 0, 2'b11, 32'h1FFC, 32'h0,        32'h00000000, 1, 32'h2002);
    add("rw_2004b", 1, 0, 2'b11, 32'h2004, 32'h0,        32'hCAFEBEEF, 1, 32'h2002);
    add("r_top",    1, 0, 2'b11, 32'h2040, 32'h0,        32'h00000000, 1, 32'h2002);
    add("wh_odd",   1, 1, 2'b01, 32'h2005, 32'hFFFF0000, 32'h00000000, 1, 32'h2002);
    add("r_rsvd",   1, 0, 2'b10, 32'h2000, 32'h0,        32'h00000000, 1, 32'h2002);
    add("rw_2004c", 1, 0, 2'b11, 32'h2004, 32'h0,        32'hCAFEBEEF, 1, 32'h2002);

    // Initial reset: outputs forced low while reset_n is low
    #2 reset_n = 1'b0;
    #1;
    chk("rst0.rd", rdata, 32'h0);
    chk("rst0.err", {31'h0, err}, 32'h0);
    chk("rst0.ea", err_addr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulse with a write held across an edge: flags clear, write suppressed
    drive(1'b1, 1'b1, 2'b11, 32'h2000, 32'hFFFF_FFFF);
    reset_n = 1'b0;
    #1;
    chk("rst1.rd", rdata, 32'h0);
    chk("rst1.err", {31'h0, err}, 32'h0);
    chk("rst1.ea", err_addr, 32'h0);
    @(posedge clk);
    idle();
    reset_n = 1'b1;
    apply('{name: "r_keep", req: 1, wr: 0, be: 2'b11, addr: 32'h2000, wd: 32'h0,
            exp_rd: 32'h5A223344, exp_err: 0, exp_ea: 32'h0});

    // Reset in the cycle after a read: the captured read is discarded
    drive(1'b1, 1'b0, 2'b11, 32'h2004, 32'h0);
    @(posedge clk);
    #1;
    chk("pend.pre", rdata, 32'hCAFEBEEF);
    reset_n = 1'b0;
    #1;
    chk("pend.rst", rdata, 32'h0);
    idle();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("pend.post", rdata, 32'h0);

    apply('{name: "r_top2", req: 1, wr: 0, be: 2'b11, addr: 32'h2040, wd: 32'h0,
            exp_rd: 32'h0, exp_err: 1, exp_ea: 32'h2040});

`ifdef YARP_DMEM_STATS_EN
    idle();
    reset_n = 1'b0;
    #1;
    chk("cnt.rst.rd", rd_cnt, 32'h0);
    chk("cnt.rst.wr", wr_cnt, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 2'b11, 32'h2008, 32'h1);
    drive(1'b1, 1'b1, 2'b00, 32'h2009, 32'h2);
    drive(1'b1, 1'b1, 2'b01, 32'h200E, 32'h3);
    drive(1'b1, 1'b0, 2'b11, 32'h2008, 32'h0);
    drive(1'b1, 1'b0, 2'b01, 32'h200E, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h2041, 32'h0);
    idle();
    @(posedge clk);
    #1;
    chk("cnt.wr", wr_cnt, 32'd3);
    chk("cnt.rd", rd_cnt, 32'd2);
    chk("cnt.err", {31'h0, err}, 32'h1);
`endif

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard: got %0d leftover entries, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
